// File: rtl/avalon_xbar_pkg.sv
// Shared types and SoC address map for the Avalon-MM crossbar.
package avalon_xbar_pkg;

  // Host index field width; covers crossbars of up to 16 hosts.
  localparam int IDX_W = 4;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK    = 32'hFFF0_0000;
  localparam logic [31:0] AON_BASE    = 32'h8000_0000;
  localparam logic [31:0] GPIO0_BASE  = 32'h8001_0000;
  localparam logic [31:0] GPIO1_BASE  = 32'h8002_0000;
  localparam logic [31:0] UART0_BASE  = 32'h8003_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_0000;

  typedef enum logic {
    ERR_IDLE = 1'b0,
    ERR_RESP = 1'b1
  } err_state_e;

  typedef struct packed {
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
  } arb_state_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int unsigned     n);
    logic [IDX_W-1:0] r;
    if (32'(idx) + 32'd1 >= n) begin
      r = '0;
    end else begin
      r = idx + IDX_W'(1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_rr_arbiter.sv
// Per-device round-robin arbiter; the grant is held from the first stalled
// cycle of a transfer until its completion.
module avalon_rr_arbiter
  import avalon_xbar_pkg::*;
#(
  parameter int NH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NH-1:0] req,
  input  logic          dev_wait,
  output logic          gnt_vld,
  output logic [NH-1:0] gnt_oh
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] eff_idx;
  logic             eff_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= state_next;
    end
  end

  // A held grant wins; otherwise scan cyclically starting at rr_ptr.
  always_comb begin
    int unsigned pos;
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    eff_idx = '0;
    pos     = 0;
    if (state.grant_vld) begin
      gnt_vld = 1'b1;
      eff_idx = state.grant_idx;
      for (int h = 0; h < NH; h++) begin
        gnt_oh[h] = (state.grant_idx == IDX_W'(h));
      end
    end else begin
      for (int k = 0; k < NH; k++) begin
        pos = 32'(state.rr_ptr) + 32'(k);
        if (pos >= NH) begin
          pos = pos - NH;
        end else begin
          pos = pos;
        end
        for (int h = 0; h < NH; h++) begin
          if (!gnt_vld && req[h] && (pos == 32'(h))) begin
            gnt_vld   = 1'b1;
            gnt_oh[h] = 1'b1;
            eff_idx   = IDX_W'(h);
          end else begin
            gnt_vld = gnt_vld;
          end
        end
      end
    end
    eff_req = |(req & gnt_oh);
  end

  always_comb begin
    state_next = state;
    if (gnt_vld && eff_req) begin
      if (dev_wait) begin
        state_next.grant_vld = 1'b1;
        state_next.grant_idx = eff_idx;
      end else begin
        state_next.grant_vld = 1'b0;
        state_next.rr_ptr    = next_idx(eff_idx, NH);
      end
    end else begin
      // Covers a granted host abandoning its request: drop the lock only.
      state_next.grant_vld = 1'b0;
    end
  end

endmodule

// File: rtl/avalon_xbar.sv
// Avalon-MM crossbar: NH hosts to ND devices, address decode, per-device
// round-robin arbitration and a decode-error responder per host.
module avalon_xbar
  import avalon_xbar_pkg::*;
#(
  parameter int NH = 3,
  parameter int ND = 5,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [ND-1:0][AW-1:0] DEV_BASE = {AW'(UART0_BASE), AW'(GPIO1_BASE),
                                               AW'(GPIO0_BASE), AW'(AON_BASE),
                                               AW'(RAM_BASE)},
  parameter logic [ND-1:0][AW-1:0] DEV_MASK = {AW'(PERIPH_MASK), AW'(PERIPH_MASK),
                                               AW'(PERIPH_MASK), AW'(PERIPH_MASK),
                                               AW'(RAM_MASK)},
  parameter logic [DW-1:0] ERR_DATA = DW'(32'h0)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NH-1:0]                h_read,
  input  logic [NH-1:0]                h_write,
  input  logic [NH-1:0][AW-1:0]        h_address,
  input  logic [NH-1:0][DW/8-1:0]      h_byte_enable,
  input  logic [NH-1:0][DW-1:0]        h_writedata,
  output logic [NH-1:0][DW-1:0]        h_readdata,
  output logic [NH-1:0]                h_waitrequest,
  output logic [NH-1:0]                h_decode_err,
  output logic [ND-1:0]                d_read,
  output logic [ND-1:0]                d_write,
  output logic [ND-1:0][AW-1:0]        d_address,
  output logic [ND-1:0][DW/8-1:0]      d_byte_enable,
  output logic [ND-1:0][DW-1:0]        d_writedata,
  input  logic [ND-1:0][DW-1:0]        d_readdata,
  input  logic [ND-1:0]                d_waitrequest
);

  logic [NH-1:0]          host_req;
  logic [NH-1:0]          mapped;
  logic [NH-1:0][ND-1:0]  sel_oh;
  logic [ND-1:0][NH-1:0]  dev_req;
  logic [ND-1:0][NH-1:0]  dev_gnt;
  logic [ND-1:0]          dev_vld;
  logic [NH-1:0]          granted;
  logic [NH-1:0]          gnt_wait;
  logic [NH-1:0][DW-1:0]  gnt_data;
  err_state_e             err_state [NH];
  err_state_e             err_next  [NH];

  // Lowest-index matching device wins the decode.
  always_comb begin
    host_req = '0;
    mapped   = '0;
    sel_oh   = '0;
    dev_req  = '0;
    for (int h = 0; h < NH; h++) begin
      host_req[h] = h_read[h] | h_write[h];
      for (int d = 0; d < ND; d++) begin
        sel_oh[h][d]  = !mapped[h] && ((h_address[h] & DEV_MASK[d]) == DEV_BASE[d]);
        mapped[h]     = mapped[h] | sel_oh[h][d];
        dev_req[d][h] = host_req[h] & sel_oh[h][d];
      end
    end
  end

  for (genvar d = 0; d < ND; d++) begin : g_arb
    avalon_rr_arbiter #(.NH(NH)) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (dev_req[d]),
      .dev_wait (d_waitrequest[d]),
      .gnt_vld  (dev_vld[d]),
      .gnt_oh   (dev_gnt[d])
    );
  end

  // Grants are one-hot per device, so forwarding is an OR of masked hosts.
  always_comb begin
    logic fwd;
    fwd           = 1'b0;
    d_read        = '0;
    d_write       = '0;
    d_address     = '0;
    d_byte_enable = '0;
    d_writedata   = '0;
    for (int d = 0; d < ND; d++) begin
      for (int h = 0; h < NH; h++) begin
        fwd              = !rst && dev_vld[d] && dev_gnt[d][h];
        d_read[d]        = d_read[d]  | (fwd & h_read[h]  & sel_oh[h][d]);
        d_write[d]       = d_write[d] | (fwd & h_write[h] & sel_oh[h][d]);
        d_address[d]     = d_address[d]     | (h_address[h]     & {AW{fwd}});
        d_byte_enable[d] = d_byte_enable[d] | (h_byte_enable[h] & {(DW/8){fwd}});
        d_writedata[d]   = d_writedata[d]   | (h_writedata[h]   & {DW{fwd}});
      end
    end
  end

  always_comb begin
    logic hit;
    hit      = 1'b0;
    granted  = '0;
    gnt_wait = '0;
    gnt_data = '0;
    for (int h = 0; h < NH; h++) begin
      for (int d = 0; d < ND; d++) begin
        hit         = sel_oh[h][d] & dev_vld[d] & dev_gnt[d][h];
        granted[h]  = granted[h]  | hit;
        gnt_wait[h] = gnt_wait[h] | (hit & d_waitrequest[d]);
        gnt_data[h] = gnt_data[h] | (d_readdata[d] & {DW{hit}});
      end
    end
  end

  always_comb begin
    h_waitrequest = '0;
    h_readdata    = '0;
    h_decode_err  = '0;
    for (int h = 0; h < NH; h++) begin
      if (rst) begin
        h_waitrequest[h] = host_req[h];
      end else if (err_state[h] == ERR_RESP) begin
        h_readdata[h]   = ERR_DATA;
        h_decode_err[h] = 1'b1;
      end else if (!host_req[h]) begin
        h_waitrequest[h] = 1'b0;
      end else if (!mapped[h] || !granted[h]) begin
        h_waitrequest[h] = 1'b1;
      end else begin
        h_waitrequest[h] = gnt_wait[h];
        h_readdata[h]    = gnt_data[h];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int h = 0; h < NH; h++) begin
      if (rst) begin
        err_state[h] <= ERR_IDLE;
      end else begin
        err_state[h] <= err_next[h];
      end
    end
  end

  // Unmapped accesses take one stall cycle, then a one-cycle error response.
  always_comb begin
    for (int h = 0; h < NH; h++) begin
      err_next[h] = ERR_IDLE;
      case (err_state[h])
        ERR_IDLE: err_next[h] = (host_req[h] && !mapped[h]) ? ERR_RESP : ERR_IDLE;
        ERR_RESP: err_next[h] = ERR_IDLE;
        default:  err_next[h] = ERR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_xbar.sv
// Self-checking bench for avalon_xbar: directed scenarios followed by random
// traffic, both checked against a transaction-level reference model.
module tb_avalon_xbar;

  localparam int NH = 3;
  localparam int ND = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DW-1:0] ERRD = 32'hBAD0_0BAD;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NH-1:0]          h_read, h_write;
  logic [NH-1:0][AW-1:0]  h_address;
  logic [NH-1:0][3:0]     h_byte_enable;
  logic [NH-1:0][DW-1:0]  h_writedata;
  logic [NH-1:0][DW-1:0]  h_readdata;
  logic [NH-1:0]          h_waitrequest, h_decode_err;
  logic [ND-1:0]          d_read, d_write;
  logic [ND-1:0][AW-1:0]  d_address;
  logic [ND-1:0][3:0]     d_byte_enable;
  logic [ND-1:0][DW-1:0]  d_writedata;
  logic [ND-1:0][DW-1:0]  d_readdata;
  logic [ND-1:0]          d_waitrequest;

  avalon_xbar #(.ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .h_read(h_read), .h_write(h_write), .h_address(h_address),
    .h_byte_enable(h_byte_enable), .h_writedata(h_writedata),
    .h_readdata(h_readdata), .h_waitrequest(h_waitrequest), .h_decode_err(h_decode_err),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_byte_enable(d_byte_enable), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dev_data(input int d, input logic [31:0] a);
    return a ^ (32'h0101_0101 * (d + 1));
  endfunction

  // Device models answer with a function of the address they are presented.
  always_comb begin
    for (int d = 0; d < ND; d++) d_readdata[d] = dev_data(d, d_address[d]);
  end

  logic [31:0] map_base [ND] = '{32'h0000_0000, 32'h8000_0000, 32'h8001_0000,
                                 32'h8002_0000, 32'h8003_0000};
  logic [31:0] map_mask [ND] = '{32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                 32'hFFFF_0000, 32'hFFFF_0000};

  int compared = 0;
  int mismatched = 0;

  // Reference model state: owner of a held grant (-1 none), RR start, error stage.
  int lock_own [ND];
  int rr       [ND];
  int err_st   [NH];
  int tgt      [NH];
  int owner    [ND];
  bit done     [NH];
  logic [69:0] exp_dev  [ND];
  logic [33:0] exp_host [NH];

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hreq(input int h);
    return h_read[h] | h_write[h];
  endfunction

  task automatic model_eval();
    int o;
    logic w;
    logic [31:0] rd;
    logic de;
    for (int h = 0; h < NH; h++) begin
      tgt[h] = -1;
      for (int d = ND - 1; d >= 0; d--)
        if ((h_address[h] & map_mask[d]) == map_base[d]) tgt[h] = d;
    end
    for (int d = 0; d < ND; d++) begin
      owner[d] = lock_own[d];
      if (owner[d] < 0) begin
        for (int k = 0; k < NH; k++) begin
          o = (rr[d] + k) % NH;
          if (owner[d] < 0 && hreq(o) && tgt[o] == d) owner[d] = o;
        end
      end
      exp_dev[d] = '0;
      if (!rst && owner[d] >= 0) begin
        o = owner[d];
        exp_dev[d] = {h_read[o] & (tgt[o] == d), h_write[o] & (tgt[o] == d),
                      h_address[o], h_byte_enable[o], h_writedata[o]};
      end
    end
    for (int h = 0; h < NH; h++) begin
      w = 1'b0; rd = '0; de = 1'b0;
      if (rst) w = hreq(h);
      else if (err_st[h] == 1) begin rd = ERRD; de = 1'b1; end
      else if (!hreq(h)) w = 1'b0;
      else if (tgt[h] < 0) w = 1'b1;
      else if (owner[tgt[h]] == h) begin
        w = d_waitrequest[tgt[h]];
        rd = dev_data(tgt[h], h_address[h]);
      end else w = 1'b1;
      exp_host[h] = {w, rd, de};
      done[h] = !rst && hreq(h) && !w;
    end
  endtask

  task automatic model_update();
    int o;
    if (rst) begin
      for (int d = 0; d < ND; d++) begin lock_own[d] = -1; rr[d] = 0; end
      for (int h = 0; h < NH; h++) err_st[h] = 0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        o = owner[d];
        if (o >= 0) begin
          if (hreq(o) && tgt[o] == d) begin
            if (d_waitrequest[d]) lock_own[d] = o;
            else begin lock_own[d] = -1; rr[d] = (o + 1) % NH; end
          end else lock_own[d] = -1;
        end
      end
      for (int h = 0; h < NH; h++) begin
        if (err_st[h] == 1) err_st[h] = 0;
        else if (hreq(h) && tgt[h] < 0) err_st[h] = 1;
      end
    end
  endtask

  task automatic check_now();
    #1;
    model_eval();
    for (int d = 0; d < ND; d++)
      chk($sformatf("dev%0d_port", d),
          {d_read[d], d_write[d], d_address[d], d_byte_enable[d], d_writedata[d]}, exp_dev[d]);
    for (int h = 0; h < NH; h++)
      chk($sformatf("host%0d_resp", h), {h_waitrequest[h], h_readdata[h], h_decode_err[h]},
          exp_host[h]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_host(input int h, input logic rd, input logic wr, input logic [31:0] a);
    h_read[h] = rd;
    h_write[h] = wr;
    h_address[h] = a;
    h_byte_enable[h] = 4'hF;
    h_writedata[h] = a ^ 32'h5A5A_0000;
  endtask

  task automatic clear_hosts();
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rand_host(input int h);
    logic [31:0] a;
    int kind;
    kind = $urandom_range(0, 9);
    a = $urandom;
    case (kind)
      0, 1, 2: a = a & 32'h000F_FFFC;
      3, 4, 5, 6, 7: a = map_base[kind - 3] | (a & 32'h0000_FFFC);
      default: a = 32'h4000_0000 | (a & 32'h0FFF_FFFC);
    endcase
    if ($urandom_range(0, 3) == 0) set_host(h, 1'b0, 1'b0, a);
    else if ($urandom_range(0, 1) == 0) set_host(h, 1'b1, 1'b0, a);
    else set_host(h, 1'b0, 1'b1, a);
    h_byte_enable[h] = 4'($urandom);
    h_writedata[h] = $urandom;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin lock_own[d] = -1; rr[d] = 0; end
    for (int h = 0; h < NH; h++) err_st[h] = 0;
    rst = 1'b1;
    clear_hosts();
    d_waitrequest = '0;
    @(negedge clk);

    // Reset: requesting host stalls, no device access.
    set_host(1, 1'b1, 1'b0, 32'h0000_0010);
    check_now();
    chk("rst_ibus_wait", h_waitrequest[1], 1'b1);
    chk("rst_d_read", d_read, 5'b00000);
    chk("rst_decode_err", h_decode_err, 3'b000);
    tick();

    // ibus read of RAM completes in its first cycle.
    rst = 1'b0;
    check_now();
    chk("p1_wait", h_waitrequest[1], 1'b0);
    chk("p1_rdata", h_readdata[1], 32'h0101_0111);
    chk("p1_d_read", d_read, 5'b00001);
    tick();

    // Simultaneous RAM reads from rr_ptr=0: ibus, then dbus.
    rst = 1'b1; clear_hosts(); check_now(); tick();
    rst = 1'b0;
    set_host(1, 1'b1, 1'b0, 32'h0000_0100);
    set_host(2, 1'b1, 1'b0, 32'h0000_0200);
    check_now();
    chk("p2_wait_first", h_waitrequest, 3'b100);
    chk("p2_addr_first", d_address[0], 32'h0000_0100);
    tick();
    set_host(1, 1'b0, 1'b0, 32'h0);
    check_now();
    chk("p2_wait_second", h_waitrequest[2], 1'b0);
    chk("p2_rdata_second", h_readdata[2], 32'h0101_0301);
    tick();
    clear_hosts();
    set_host(0, 1'b1, 1'b0, 32'h0000_0300);
    set_host(1, 1'b1, 1'b0, 32'h0000_0400);
    check_now();
    chk("p2_rr_back_to_0", h_waitrequest, 3'b010);
    tick();
    set_host(0, 1'b0, 1'b0, 32'h0);
    check_now();
    tick();

    // dbus writes UART0 while ibus reads RAM: parallel completion.
    set_host(1, 1'b1, 1'b0, 32'h0000_0500);
    set_host(2, 1'b0, 1'b1, 32'h8003_0004);
    check_now();
    chk("p3_wait", h_waitrequest, 3'b000);
    chk("p3_d_read", d_read, 5'b00001);
    chk("p3_d_write", d_write, 5'b10000);
    chk("p3_uart_wdata", d_writedata[4], 32'h8003_0004 ^ 32'h5A5A_0000);
    tick();

    // Unmapped read: stall, then error response.
    clear_hosts();
    set_host(2, 1'b1, 1'b0, 32'h4000_0000);
    check_now();
    chk("p4_c1_wait", h_waitrequest[2], 1'b1);
    chk("p4_c1_derr", h_decode_err, 3'b000);
    tick();
    check_now();
    chk("p4_c2_wait", h_waitrequest[2], 1'b0);
    chk("p4_c2_derr", h_decode_err, 3'b100);
    chk("p4_c2_rdata", h_readdata[2], ERRD);
    tick();
    clear_hosts();
    check_now();
    chk("p4_derr_clear", h_decode_err, 3'b000);
    tick();

    // RAM stalls ibus for 3 cycles while dbus waits; grant holds.
    set_host(1, 1'b1, 1'b0, 32'h0000_0600);
    d_waitrequest[0] = 1'b1;
    check_now();
    chk("p5_lock_wait", h_waitrequest[1], 1'b1);
    tick();
    set_host(2, 1'b1, 1'b0, 32'h0000_0700);
    for (int i = 0; i < 2; i++) begin
      check_now();
      chk("p5_addr_stable", d_address[0], 32'h0000_0600);
      chk("p5_both_wait", h_waitrequest, 3'b110);
      tick();
    end
    d_waitrequest[0] = 1'b0;
    check_now();
    chk("p5_ibus_done", h_waitrequest, 3'b100);
    tick();
    set_host(1, 1'b0, 1'b0, 32'h0);
    check_now();
    chk("p5_dbus_addr", d_address[0], 32'h0000_0700);
    chk("p5_dbus_done", h_waitrequest[2], 1'b0);
    tick();

    // Reset during a locked transfer clears lock and rr pointer.
    clear_hosts();
    set_host(1, 1'b1, 1'b0, 32'h0000_0800);
    d_waitrequest[0] = 1'b1;
    check_now();
    tick();
    rst = 1'b1;
    check_now();
    chk("p6_rst_d_read", d_read, 5'b00000);
    tick();
    rst = 1'b0;
    d_waitrequest[0] = 1'b0;
    clear_hosts();
    set_host(0, 1'b1, 1'b0, 32'h0000_0900);
    set_host(2, 1'b1, 1'b0, 32'h0000_0A00);
    check_now();
    chk("p6_after_rst_grant", h_waitrequest, 3'b100);
    chk("p6_after_rst_addr", d_address[0], 32'h0000_0900);
    tick();
    clear_hosts();
    check_now();
    tick();

    // Random traffic: hosts hold requests until completion.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < ND; d++) d_waitrequest[d] = ($urandom_range(0, 2) == 0);
      for (int h = 0; h < NH; h++) begin
        if (!hreq(h) || done[h]) rand_host(h);
        else if ($urandom_range(0, 99) == 0) begin h_read[h] = 1'b0; h_write[h] = 1'b0; end
      end
      check_now();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
